game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// Game controller: per-frame hit resolution, alive mask, IDLE/PLAY/WIN/LOSE FSM.
// Optional kill score is enabled by defining GAME_CTRL_SCORE_EN.
module game_ctrl #(
  parameter int N_ALIEN     = 15,
  parameter int N_MISSLE    = 8,
  parameter int SCORE_W     = 12,
  parameter int HOLD_FRAMES = 120
) (
  input  logic                vga_clk_i,
  input  logic                vga_rst_i,
  input  logic                frame_start_i,
  input  logic                video_on_i,
  input  logic [N_ALIEN-1:0]  alien_active_i,
  input  logic [N_MISSLE-1:0] missle_active_i,
  input  logic                landed_i,
  input  logic                start_i,
  output logic [N_ALIEN-1:0]  alien_alive_o,
  output logic [N_MISSLE-1:0] missle_clear_o,
  output logic [1:0]          state_o,
  output logic                winner_o,
  output logic                loser_o,
  output logic [SCORE_W-1:0]  score_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_e;

  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  state_e                state_q;
  logic [N_ALIEN-1:0]    alive_q, alive_d;
  logic [N_ALIEN-1:0]    hit_pend_q;
  logic [N_MISSLE-1:0]   miss_pend_q;
  logic [N_MISSLE-1:0]   clear_q;
  logic [HOLD_W-1:0]     hold_q;

  logic [N_ALIEN-1:0]    target;
  logic [N_ALIEN-1:0]    hit_now;
  logic [N_MISSLE-1:0]   miss_now;

  always_comb begin
    target   = alien_active_i & alive_q;
    hit_now  = (video_on_i && (|missle_active_i)) ? target : '0;
    miss_now = (video_on_i && (|target)) ? missle_active_i : '0;
    alive_d  = alive_q & ~hit_pend_q;
  end

  // Frame-start commit takes the old pending set; this cycle's hits seed the new frame.
  always_ff @(posedge vga_clk_i) begin
    if (!vga_rst_i) begin
      state_q     <= IDLE;
      alive_q     <= '1;
      hit_pend_q  <= '0;
      miss_pend_q <= '0;
      clear_q     <= '0;
      hold_q      <= '0;
    end else begin
      clear_q <= '0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q     <= PLAY;
            alive_q     <= '1;
            hit_pend_q  <= '0;
            miss_pend_q <= '0;
          end
        end
        PLAY: begin
          if (frame_start_i) begin
            alive_q <= alive_d;
            if (landed_i || (alive_d == '0)) begin
              state_q     <= landed_i ? LOSE : WIN;
              hit_pend_q  <= '0;
              miss_pend_q <= '0;
              hold_q      <= '0;
            end else begin
              clear_q     <= miss_pend_q;
              hit_pend_q  <= hit_now;
              miss_pend_q <= miss_now;
            end
          end else if (landed_i) begin
            state_q     <= LOSE;
            hit_pend_q  <= '0;
            miss_pend_q <= '0;
            hold_q      <= '0;
          end else begin
            hit_pend_q  <= hit_pend_q | hit_now;
            miss_pend_q <= miss_pend_q | miss_now;
          end
        end
        default: begin
          if (start_i && (hold_q == HOLD_W'(HOLD_FRAMES))) begin
            state_q <= IDLE;
          end else if (frame_start_i && (hold_q != HOLD_W'(HOLD_FRAMES))) begin
            hold_q <= hold_q + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef GAME_CTRL_SCORE_EN
  localparam int unsigned PC_W  = $clog2(N_ALIEN + 1);
  localparam int unsigned SUM_W = SCORE_W + PC_W + 4;
  localparam logic [SUM_W-1:0] SMAX = SUM_W'({SCORE_W{1'b1}});

  logic [SCORE_W-1:0] score_q;
  logic [N_ALIEN-1:0] kill_mask;
  logic [PC_W-1:0]    kills;
  logic [SUM_W-1:0]   sum;

  always_comb begin
    kill_mask = hit_pend_q & alive_q;
    kills     = '0;
    for (int unsigned i = 0; i < N_ALIEN; i++) begin
      kills = kills + PC_W'(kill_mask[i]);
    end
    sum = SUM_W'(score_q) + SUM_W'(kills) * SUM_W'(10);
  end

  always_ff @(posedge vga_clk_i) begin
    if (!vga_rst_i) begin
      score_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      score_q <= '0;
    end else if (state_q == PLAY && frame_start_i) begin
      score_q <= (sum > SMAX) ? '1 : sum[SCORE_W-1:0];
    end
  end

  assign score_o = score_q;
`else
  assign score_o = '0;
`endif

  assign alien_alive_o  = alive_q;
  assign missle_clear_o = clear_q;
  assign state_o        = state_q;
  assign winner_o       = (state_q == WIN);
  assign loser_o        = (state_q == LOSE);

endmodule
